// File: rtl/reg_dump_unit.sv
// rtl/reg_dump_unit.sv - register bank dump engine streaming {index, data} beats
//
// Walks an inclusive index range on a spare read port of the 32x32 register
// bank. Each index is read for one cycle, and then held as a beat until the
// consumer accepts it.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               one-cycle dump request (only honoured when idle)
//   i_first_idx/i_last_idx inclusive index range, sampled with i_start
//   i_abort               cancel an active dump (ignored when idle)
//   o_rd_addr, i_rd_data  bank read port (combinational data for o_rd_addr)
//   o_out_valid/i_out_ready/o_out_idx/o_out_data/o_out_last  beat stream
//   o_busy                engine not idle
//   o_done                pulse after the final beat is accepted
//   o_err                 pulse after a start with an empty (reversed) range
module reg_dump_unit #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [IDX_W-1:0] i_first_idx,
    input  logic [IDX_W-1:0] i_last_idx,
    input  logic             i_abort,
    output logic [IDX_W-1:0] o_rd_addr,
    input  logic [XLEN-1:0]  i_rd_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [IDX_W-1:0] o_out_idx,
    output logic [XLEN-1:0]  o_out_data,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_cur;
    logic [IDX_W-1:0] r_end;
    logic [XLEN-1:0]  r_data_q;
    logic [IDX_W-1:0] r_rd_addr;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_done;
    logic             r_err;

    logic             w_handshake;
    logic             w_at_end;

    assign w_handshake = r_out_valid && i_out_ready;
    // Range end is compared for equality only, so the index never wraps past it.
    assign w_at_end    = (r_cur == r_end);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_end       <= '0;
            r_data_q    <= '0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == S_IDLE) begin
                // Abort has no meaning here, so a simultaneous start wins.
                r_rd_addr <= '0;
                if (i_start) begin
                    if (i_first_idx <= i_last_idx) begin
                        r_cur     <= i_first_idx;
                        r_end     <= i_last_idx;
                        r_rd_addr <= i_first_idx;
                        r_state   <= S_READ;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (i_abort) begin
                // A beat accepted in this same cycle is already delivered;
                // nothing else is emitted and no done pulse follows.
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_rd_addr   <= '0;
            end else begin
                case (r_state)
                    S_READ: begin
                        r_data_q    <= i_rd_data;
                        r_out_idx   <= r_cur;
                        r_out_last  <= w_at_end;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_handshake) begin
                            r_out_valid <= 1'b0;
                            if (w_at_end) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_cur     <= r_cur + IDX_W'(1);
                                r_rd_addr <= r_cur + IDX_W'(1);
                                r_state   <= S_READ;
                            end
                        end
                    end
                    S_DONE: begin
                        r_rd_addr <= '0;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_idx   = r_out_idx;
    assign o_out_data  = r_data_q;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb/tb_reg_dump_unit.sv - directed self-checking bench for reg_dump_unit
module tb_reg_dump_unit;

    localparam int XLEN  = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [IDX_W-1:0] i_first_idx = '0;
    logic [IDX_W-1:0] i_last_idx = '0;
    logic             i_abort = 1'b0;
    logic [IDX_W-1:0] o_rd_addr;
    logic [XLEN-1:0]  i_rd_data;
    logic             o_out_valid;
    logic             i_out_ready = 1'b0;
    logic [IDX_W-1:0] o_out_idx;
    logic [XLEN-1:0]  o_out_data;
    logic             o_out_last;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    logic [XLEN-1:0] bank [32];

    int n_pass  = 0;
    int n_total = 0;

    int          q_idx  [$];
    logic [31:0] q_data [$];
    logic        q_last [$];
    int          q_cyc  [$];

    always #5 clk = ~clk;

    assign i_rd_data = (o_rd_addr == '0) ? '0 : bank[o_rd_addr];

    reg_dump_unit #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_first_idx (i_first_idx),
        .i_last_idx  (i_last_idx),
        .i_abort     (i_abort),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_idx   (o_out_idx),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse start at a negedge; returns at the negedge of cycle 1.
    task automatic do_start(input int f, input int l);
        i_start     = 1'b1;
        i_first_idx = IDX_W'(f);
        i_last_idx  = IDX_W'(l);
        tick();
        i_start = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: fixed irregular ready pattern;
    // mode 2: ready high, write x5 on beat-3 handshake, stray start in cycle 4.
    task automatic collect(input int mode, input int max_cyc,
                           output int ndone, output int done_cyc, output logic busy_after);
        logic [15:0]      pat;
        logic             pv, pr;
        logic [IDX_W-1:0] pidx;
        logic [XLEN-1:0]  pdata;
        int               cyc;
        pat = 16'b1011_0010_0110_1001;
        q_idx.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
        ndone = 0; done_cyc = -1; busy_after = 1'b1;
        pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0;
        cyc = 1;
        while (cyc < max_cyc) begin
            i_out_ready = (mode == 1) ? pat[cyc % 16] : 1'b1;
            if (mode == 2 && cyc == 4) begin
                i_start = 1'b1; i_first_idx = 5'd20; i_last_idx = 5'd21;
            end else begin
                i_start = 1'b0;
            end
            if (pv && !pr) begin
                chk("hold_valid", o_out_valid, 1'b1);
                chk("hold_idx", o_out_idx, pidx);
                chk("hold_data", o_out_data, pdata);
            end
            if (o_done) begin ndone++; done_cyc = cyc; end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = o_busy;
                break;
            end
            if (o_out_valid && i_out_ready) begin
                q_idx.push_back(int'(o_out_idx));
                q_data.push_back(o_out_data);
                q_last.push_back(o_out_last);
                q_cyc.push_back(cyc);
                if (mode == 2 && o_out_idx == 5'd3) bank[5] = 32'hDEAD_BEEF;
            end
            pv = o_out_valid; pr = i_out_ready; pidx = o_out_idx; pdata = o_out_data;
            tick();
            cyc++;
        end
        i_start = 1'b0;
        i_out_ready = 1'b0;
    endtask

    int   nd, dc, hs;
    logic ba;
    logic found;

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h1111_0000 + i;
        bank[0] = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_valid", o_out_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_idx_data", {o_out_idx, o_out_data, o_out_last, o_done, o_err}, 0);
        i_rst = 1'b0;
        tick();

        // Full dump 0..31
        do_start(0, 31);
        collect(0, 120, nd, dc, ba);
        chk("full_nbeats", q_idx.size(), 32);
        for (int k = 0; k < 32 && k < q_idx.size(); k++) begin
            chk($sformatf("full_idx%0d", k), q_idx[k], k);
            chk($sformatf("full_data%0d", k), q_data[k], (k == 0) ? 32'h0 : 32'h1111_0000 + k);
            chk($sformatf("full_last%0d", k), q_last[k], (k == 31) ? 1 : 0);
            chk($sformatf("full_cyc%0d", k), q_cyc[k], 2 + 2 * k);
        end
        chk("full_done_cyc", dc, 65);
        chk("full_ndone", nd, 1);
        chk("full_busy66", ba, 0);
        tick();

        // Backpressure 4..6
        do_start(4, 6);
        collect(1, 80, nd, dc, ba);
        chk("bp_nbeats", q_idx.size(), 3);
        for (int k = 0; k < 3 && k < q_idx.size(); k++) begin
            chk($sformatf("bp_idx%0d", k), q_idx[k], 4 + k);
            chk($sformatf("bp_data%0d", k), q_data[k], 32'h1111_0004 + k);
        end
        chk("bp_ndone", nd, 1);
        tick();

        // Single register 10..10, with abort in the same idle cycle as start
        i_abort = 1'b1;
        do_start(10, 10);
        i_abort = 1'b0;
        chk("single_busy", o_busy, 1);
        collect(0, 20, nd, dc, ba);
        chk("single_nbeats", q_idx.size(), 1);
        if (q_idx.size() > 0) begin
            chk("single_idx", q_idx[0], 10);
            chk("single_last", q_last[0], 1);
        end
        chk("single_ndone", nd, 1);
        tick();

        // Reversed range 12..3
        do_start(12, 3);
        chk("err_pulse", o_err, 1);
        chk("err_busy", o_busy, 0);
        tick();
        chk("err_clear", o_err, 0);
        chk("err_novalid", o_out_valid, 0);
        tick();

        // Abort during SEND of idx 7, no handshake, then with handshake
        for (int rep = 0; rep < 2; rep++) begin
            do_start(0, 31);
            hs = 0; found = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (o_out_valid && o_out_idx == 5'd7) begin
                    found = 1'b1;
                    i_out_ready = (rep == 1);
                    i_abort = 1'b1;
                    if (rep == 1) hs++;
                    break;
                end
                i_out_ready = 1'b1;
                if (o_out_valid) hs++;
                tick();
            end
            chk($sformatf("abort%0d_found", rep), found, 1);
            tick();
            i_abort = 1'b0;
            i_out_ready = 1'b1;
            chk($sformatf("abort%0d_valid", rep), o_out_valid, 0);
            chk($sformatf("abort%0d_busy", rep), o_busy, 0);
            chk($sformatf("abort%0d_done", rep), o_done, 0);
            chk($sformatf("abort%0d_delivered", rep), hs, (rep == 1) ? 8 : 7);
            nd = 0;
            for (int c = 0; c < 6; c++) begin
                if (o_done || o_out_valid) nd++;
                tick();
            end
            chk($sformatf("abort%0d_quiet", rep), nd, 0);
            i_out_ready = 1'b0;
        end

        // Reset during READ of idx 20
        do_start(0, 31);
        i_out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (o_busy && !o_out_valid && o_rd_addr == 5'd20) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rstmid_found", found, 1);
        i_rst = 1'b1;
        #1;
        chk("rstmid_outs", {o_rd_addr, o_out_valid, o_out_idx, o_out_data, o_out_last,
                            o_busy, o_done, o_err}, 0);
        tick(); tick();
        i_rst = 1'b0;
        i_out_ready = 1'b0;
        tick();
        chk("rstmid_idle", {o_busy, o_out_valid, o_done}, 0);
        do_start(0, 1);
        collect(0, 20, nd, dc, ba);
        chk("rstmid_nbeats", q_idx.size(), 2);
        if (q_idx.size() == 2) begin
            chk("rstmid_idx0", q_idx[0], 0);
            chk("rstmid_idx1", q_idx[1], 1);
            chk("rstmid_data1", q_data[1], 32'h1111_0001);
        end
        chk("rstmid_ndone", nd, 1);
        tick();

        // Live write of x5 and stray start during dump 0..7
        do_start(0, 7);
        collect(2, 60, nd, dc, ba);
        chk("live_nbeats", q_idx.size(), 8);
        if (q_idx.size() == 8) begin
            chk("live_data4", q_data[4], 32'h1111_0004);
            chk("live_data5", q_data[5], 32'hDEAD_BEEF);
            chk("live_idx7", q_idx[7], 7);
        end
        chk("live_ndone", nd, 1);
        tick();
        chk("live_idle_after", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
